fetch_stage: RTL

Instruction-fetch stage of the pipelined core. Owns the 8-bit PC, drives a synchronous-read instruction memory, and presents `PCPlus1` and `instruction` to the IF/ID pipeline register. Selects the next PC from branch and jump redirects, stalls, or sequential increment, and raises the IF/ID flush on redirects. Keeps saturating fetch, stall and redirect statistics counters for debug.

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_sat_counter.sv | 20 ++
 rtl/fetch_stage.sv | 96 +++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared pipeline constants and next-PC select encoding
package fetch_stage_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0]    RESET_PC  = '0;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  // Next-PC source, listed from highest to lowest priority
  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_HOLD,
    SEL_SEQ
  } pc_sel_e;

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// rtl/fetch_stage_sat_counter.sv - saturating event counter for fetch statistics
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc and stick at all-ones rather than wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, next-PC select, imem address, stats
module fetch_stage #(
  parameter int                  PC_W     = fetch_stage_pkg::PC_W,
  parameter int                  INSTR_W  = fetch_stage_pkg::INSTR_W,
  parameter logic [PC_W-1:0]     RESET_PC = fetch_stage_pkg::RESET_PC,
  parameter int                  CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Write_PC,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    PCPlus1,
  output logic [INSTR_W-1:0] instruction,
  output logic               flush_IF,
  output logic [PC_W-1:0]    pc,
  output logic [CNT_W-1:0]   fetch_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   redirect_cnt
);

  import fetch_stage_pkg::*;

  logic            primed;
  pc_sel_e         pc_sel;
  logic [PC_W-1:0] pc_next;

  // Pick the next-PC source; redirects beat a stall since the stalled slot is wrong-path
  always_comb begin
    pc_sel = SEL_SEQ;
    if (!primed) begin
      pc_sel = SEL_RESET;
    end else if (branch_taken) begin
      pc_sel = SEL_BRANCH;
    end else if (jump) begin
      pc_sel = SEL_JUMP;
    end else if (!Write_PC) begin
      pc_sel = SEL_HOLD;
    end
  end

  // Next-PC mux; sequential increment wraps at PC_W bits
  always_comb begin
    pc_next = pc + 1'b1;
    case (pc_sel)
      SEL_RESET:  pc_next = RESET_PC;
      SEL_BRANCH: pc_next = branch_target;
      SEL_JUMP:   pc_next = jump_target;
      SEL_HOLD:   pc_next = pc;
      default:    pc_next = pc + 1'b1;
    endcase
  end

  // PC register and the priming flag that masks the first, not-yet-valid read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      primed <= 1'b0;
    end else begin
      pc     <= pc_next;
      primed <= 1'b1;
    end
  end

  // Memory is addressed with pc_next so its registered read lines up with pc
  assign imem_addr   = pc_next;
  assign instruction = primed ? imem_rdata : INSTR_W'(NOP_INSTR);
  assign PCPlus1     = pc + 1'b1;
  assign flush_IF    = branch_taken | jump;

  sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (primed && (pc_sel == SEL_SEQ)),
    .count (fetch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (primed && (pc_sel == SEL_HOLD)),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (primed && ((pc_sel == SEL_BRANCH) || (pc_sel == SEL_JUMP))),
    .count (redirect_cnt)
  );

endmodule
